// File: rtl/hazard_ctl_if.sv
// +----------------------------------------------------------------------------+
// | hazard_ctl_if : decode/execute/memory status in, stall/flush controls out   |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

interface hazard_ctl_if;
    logic [31:0] instr_de;
    logic [31:0] instr_exe;
    logic        br_taken;
    logic        dmem_req;
    logic        dmem_ready;
    logic        stall_fe;
    logic        stall_ex;
    logic        flush_de;
    logic        hold_pipe;
    logic        mem_err;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    modport master (
        output instr_de, instr_exe, br_taken, dmem_req, dmem_ready,
        input  stall_fe, stall_ex, flush_de, hold_pipe, mem_err,
               perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  instr_de, instr_exe, br_taken, dmem_req, dmem_ready,
        output stall_fe, stall_ex, flush_de, hold_pipe, mem_err,
               perf_stall_cnt, perf_flush_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctl.sv
// +----------------------------------------------------------------------------+
// | hazard_ctl : load-use stall, taken-branch flush and memory-wait freeze FSM  |
// | Optional   : HAZARD_PERF_CNT_EN enables the stall/flush perf counters       |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_ctl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] flush_cnt, flush_cnt_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             ret_flush, ret_flush_nxt;

    logic stall_fe_c, stall_ex_c, flush_de_c, hold_pipe_c, mem_err_c;
    logic flush_accept;

    logic [6:0] op_de, op_exe;
    logic [4:0] rd_exe, rs1_de, rs2_de;
    logic       uses_rs1, uses_rs2, lu, mem_miss;

    assign op_de  = bus.instr_de[6:0];
    assign op_exe = bus.instr_exe[6:0];
    assign rd_exe = bus.instr_exe[11:7];
    assign rs1_de = bus.instr_de[19:15];
    assign rs2_de = bus.instr_de[24:20];

    assign uses_rs1 = !((op_de == OP_LUI) || (op_de == OP_AUIPC) || (op_de == OP_JAL));
    assign uses_rs2 = (op_de == OP_R) || (op_de == OP_S) || (op_de == OP_B);
    assign lu       = (op_exe == OP_LOAD) && (rd_exe != 5'd0) &&
                      (((rd_exe == rs1_de) && uses_rs1) || ((rd_exe == rs2_de) && uses_rs2));
    assign mem_miss = bus.dmem_req && !bus.dmem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
            wait_cnt  <= '0;
            ret_flush <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            ret_flush <= ret_flush_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        wait_cnt_nxt  = wait_cnt;
        ret_flush_nxt = ret_flush;
        stall_fe_c    = 1'b0;
        stall_ex_c    = 1'b0;
        flush_de_c    = 1'b0;
        hold_pipe_c   = 1'b0;
        mem_err_c     = 1'b0;
        flush_accept  = 1'b0;

        case (state)
            RUN: begin
                if (mem_miss) begin
                    hold_pipe_c   = 1'b1;
                    stall_fe_c    = 1'b1;
                    state_nxt     = MEM_WAIT;
                    wait_cnt_nxt  = CNT_ONE;
                    ret_flush_nxt = 1'b0;
                end else if (bus.br_taken) begin
                    flush_de_c   = 1'b1;
                    stall_ex_c   = 1'b1;
                    flush_accept = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = FLUSH_RELOAD;
                    end
                end else if (lu) begin
                    stall_fe_c = 1'b1;
                    stall_ex_c = 1'b1;
                end
            end

            FLUSH: begin
                // A frozen flush cycle does not consume flush count; it resumes after the wait.
                if (mem_miss) begin
                    hold_pipe_c   = 1'b1;
                    stall_fe_c    = 1'b1;
                    state_nxt     = MEM_WAIT;
                    wait_cnt_nxt  = CNT_ONE;
                    ret_flush_nxt = 1'b1;
                end else begin
                    flush_de_c = 1'b1;
                    stall_ex_c = 1'b1;
                    if (bus.br_taken) begin
                        flush_accept  = 1'b1;
                        flush_cnt_nxt = FLUSH_RELOAD;
                    end else if (flush_cnt <= CNT_ONE) begin
                        state_nxt     = RUN;
                        flush_cnt_nxt = '0;
                    end else begin
                        flush_cnt_nxt = flush_cnt - CNT_ONE;
                    end
                end
            end

            MEM_WAIT: begin
                // wait_cnt numbers the cycles spent in this state, starting at 1.
                if (bus.dmem_ready) begin
                    state_nxt     = ret_flush ? FLUSH : RUN;
                    wait_cnt_nxt  = '0;
                    ret_flush_nxt = 1'b0;
                end else if (wait_cnt >= TIMEOUT_VAL) begin
                    mem_err_c     = 1'b1;
                    state_nxt     = RUN;
                    flush_cnt_nxt = '0;
                    wait_cnt_nxt  = '0;
                    ret_flush_nxt = 1'b0;
                end else begin
                    hold_pipe_c = 1'b1;
                    stall_fe_c  = 1'b1;
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt_nxt = wait_cnt + CNT_ONE;
                    end
                end
            end

            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign bus.stall_fe  = stall_fe_c  & ~rst;
    assign bus.stall_ex  = stall_ex_c  & ~rst;
    assign bus.flush_de  = flush_de_c  & ~rst;
    assign bus.hold_pipe = hold_pipe_c & ~rst;
    assign bus.mem_err   = mem_err_c   & ~rst;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_fe_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_accept && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_flush_cnt = flush_cnt_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.instr_exe[31:12], bus.instr_de[31:25], bus.instr_de[14:7]};
`else
    assign bus.perf_stall_cnt = 32'h0;
    assign bus.perf_flush_cnt = 32'h0;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.instr_exe[31:12], bus.instr_de[31:25], bus.instr_de[14:7],
                         flush_accept};
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctl.sv
// +----------------------------------------------------------------------------+
// | tb_hazard_ctl : scoreboard bench with a behavioural hazard reference model  |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hazard_ctl;

    localparam int FLUSH_CYCLES = 2;
    localparam int MEM_TIMEOUT  = 15;
    localparam int CNT_W        = 4;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] LW_X5  = 32'h0000_A283;
    localparam logic [31:0] LW_X0  = 32'h0000_A003;
    localparam logic [31:0] ADD_US = 32'h0072_8333;
    localparam logic [31:0] ADD_00 = 32'h0000_0333;
    localparam logic [31:0] LUI_X6 = 32'h0002_8337;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_ctl_if bus ();

    hazard_ctl #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sfe;
        logic        sex;
        logic        fde;
        logic        hold;
        logic        err;
        logic [31:0] pstall;
        logic [31:0] pflush;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: remaining flush cycles, wait progress and event totals.
    int flush_rem   = 0;
    bit in_wait     = 0;
    int waited      = 0;
    int saved_flush = 0;
    int n_stall     = 0;
    int n_flush     = 0;

    function automatic bit load_use(logic [31:0] de, logic [31:0] exe);
        logic [4:0] rd;
        bit r1, r2;
        if (exe[6:0] != 7'b0000011) return 1'b0;
        rd = exe[11:7];
        if (rd == 5'd0) return 1'b0;
        r1 = !(de[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
        r2 = de[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
        return (r1 && rd == de[19:15]) || (r2 && rd == de[24:20]);
    endfunction

    function automatic logic [31:0] perf(int n);
`ifdef HAZARD_PERF_CNT_EN
        return 32'(n);
`else
        return (n < 0) ? 32'h1 : 32'h0;
`endif
    endfunction

    task automatic drive(input logic [31:0] de, input logic [31:0] exe,
                         input logic br, input logic req, input logic rdy);
        bus.instr_de   = de;
        bus.instr_exe  = exe;
        bus.br_taken   = br;
        bus.dmem_req   = req;
        bus.dmem_ready = rdy;
    endtask

    task automatic step(input logic [31:0] de, input logic [31:0] exe,
                        input logic br, input logic req, input logic rdy);
        exp_t e;
        bit   miss;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(de, exe, br, req, rdy);
        e = '{sfe: 1'b0, sex: 1'b0, fde: 1'b0, hold: 1'b0, err: 1'b0,
              pstall: perf(n_stall), pflush: perf(n_flush)};
        miss = req && !rdy;
        if (in_wait) begin
            if (rdy) begin
                in_wait   = 0;
                flush_rem = saved_flush;
            end else if (waited == MEM_TIMEOUT) begin
                e.err     = 1'b1;
                in_wait   = 0;
                flush_rem = 0;
            end else begin
                e.hold = 1'b1;
                e.sfe  = 1'b1;
                waited++;
            end
        end else if (miss) begin
            e.hold      = 1'b1;
            e.sfe       = 1'b1;
            in_wait     = 1;
            waited      = 1;
            saved_flush = flush_rem;
        end else if (br) begin
            e.fde     = 1'b1;
            e.sex     = 1'b1;
            n_flush++;
            flush_rem = FLUSH_CYCLES - 1;
        end else if (flush_rem > 0) begin
            e.fde = 1'b1;
            e.sex = 1'b1;
            flush_rem--;
        end else if (load_use(de, exe)) begin
            e.sfe = 1'b1;
            e.sex = 1'b1;
        end
        if (e.sfe) n_stall++;
        q.push_back(e);
    endtask

    task automatic rst_step(input logic [31:0] de, input logic [31:0] exe,
                            input logic br, input logic req, input logic rdy);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(de, exe, br, req, rdy);
        flush_rem = 0;
        in_wait   = 0;
        waited    = 0;
        n_stall   = 0;
        n_flush   = 0;
        e = '{sfe: 1'b0, sex: 1'b0, fde: 1'b0, hold: 1'b0, err: 1'b0,
              pstall: 32'h0, pflush: 32'h0};
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall_fe",       32'(bus.stall_fe),  32'(e.sfe));
                chk("stall_ex",       32'(bus.stall_ex),  32'(e.sex));
                chk("flush_de",       32'(bus.flush_de),  32'(e.fde));
                chk("hold_pipe",      32'(bus.hold_pipe), 32'(e.hold));
                chk("mem_err",        32'(bus.mem_err),   32'(e.err));
                chk("perf_stall_cnt", bus.perf_stall_cnt, e.pstall);
                chk("perf_flush_cnt", bus.perf_flush_cnt, e.pflush);
            end
        end
    end

    function automatic logic [31:0] rand_instr(bit want_load);
        logic [6:0]  ops [8] = '{7'b0000011, 7'b0110011, 7'b0100011, 7'b1100011,
                                 7'b0110111, 7'b0010111, 7'b1101111, 7'b0010011};
        logic [31:0] ins;
        ins        = $urandom;
        ins[6:0]   = want_load ? 7'b0000011 : ops[$urandom_range(0, 7)];
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    initial begin : stimulus
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        // Reset state, even with active-looking inputs.
        rst_step(ADD_US, LW_X5, 1'b1, 1'b1, 1'b0);
        rst_step(NOP, NOP, 1'b0, 1'b0, 1'b0);

        // Load-use then bubble.
        step(ADD_US, LW_X5, 1'b0, 1'b0, 1'b0);
        step(ADD_US, NOP,   1'b0, 1'b0, 1'b0);
        // No-hazard cases.
        step(ADD_00, LW_X0, 1'b0, 1'b0, 1'b0);
        step(LUI_X6, LW_X5, 1'b0, 1'b0, 1'b0);

        // Branch flush; hazard in decode during flush is ignored.
        step(NOP, NOP, 1'b1, 1'b0, 1'b0);
        step(ADD_US, LW_X5, 1'b0, 1'b0, 1'b0);
        step(NOP, NOP, 1'b0, 1'b0, 1'b0);

        // Memory wait, ready after 3 held cycles.
        repeat (3) step(NOP, NOP, 1'b0, 1'b1, 1'b0);
        step(NOP, NOP, 1'b0, 1'b1, 1'b1);
        step(NOP, NOP, 1'b0, 1'b0, 1'b0);

        // Timeout: entry plus MEM_TIMEOUT wait cycles.
        repeat (1 + MEM_TIMEOUT) step(NOP, NOP, 1'b0, 1'b1, 1'b0);
        step(NOP, NOP, 1'b0, 1'b0, 1'b0);
        // Ready arriving on the timeout cycle wins.
        repeat (MEM_TIMEOUT) step(NOP, NOP, 1'b0, 1'b1, 1'b0);
        step(NOP, NOP, 1'b0, 1'b1, 1'b1);
        step(NOP, NOP, 1'b0, 1'b0, 1'b0);

        // Memory wait interrupting a flush resumes the flush.
        step(NOP, NOP, 1'b1, 1'b0, 1'b0);
        repeat (2) step(NOP, NOP, 1'b0, 1'b1, 1'b0);
        step(NOP, NOP, 1'b0, 1'b1, 1'b1);
        repeat (2) step(NOP, NOP, 1'b0, 1'b0, 1'b0);

        // Reset mid-FLUSH.
        step(NOP, NOP, 1'b1, 1'b0, 1'b0);
        rst_step(NOP, NOP, 1'b1, 1'b0, 1'b0);
        step(NOP, NOP, 1'b0, 1'b0, 1'b0);
        step(NOP, NOP, 1'b0, 1'b0, 1'b0);

        // Reset mid-MEM_WAIT.
        repeat (2) step(NOP, NOP, 1'b0, 1'b1, 1'b0);
        rst_step(NOP, NOP, 1'b0, 1'b1, 1'b0);
        step(NOP, NOP, 1'b0, 1'b0, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            logic        br, req, rdy;
            logic [31:0] de, exe;
            exe = rand_instr($urandom_range(0, 1) == 0);
            de  = rand_instr(1'b0);
            br  = ($urandom_range(0, 7) == 0);
            req = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 1) == 0);
            step(de, exe, br, req, rdy);
        end

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
